maze_move_gate: RTL

- Feeds the movement-permission inputs of the player object: upEnable/downEnable/leftEnable/rightEnable and playerDisable.
- Takes the player's current hPos/vPos and converts them to a maze tile coordinate by sequential division.
- Reads the four neighbour tiles and the player's own tile from the external maze map memory, then publishes registered enables.
- Sits between the player object and the maze map ROM, clocked on slowClk.

---
 rtl/maze_move_gate_pkg.sv | 29 ++
 rtl/maze_move_gate_tile_divider.sv | 36 +++
 rtl/maze_move_gate.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/maze_move_gate_pkg.sv
// Shared maze constants: default tile geometry, tile-type codes and the
// movement-gate state encoding. Used by the gate, the player and the renderer.
package maze_move_gate_pkg;

    localparam int DEF_TILE     = 12;
    localparam int DEF_H_ORIGIN = 128;
    localparam int DEF_V_ORIGIN = 12;
    localparam int DEF_COLS     = 32;
    localparam int DEF_ROWS     = 38;
    localparam int DEF_AW       = 11;

    localparam logic [1:0] TILE_FLOOR  = 2'd0;
    localparam logic [1:0] TILE_WALL   = 2'd1;
    localparam logic [1:0] TILE_HAZARD = 2'd2;
    localparam logic [1:0] TILE_GOAL   = 2'd3;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DIV_H    = 4'd1,
        DIV_V    = 4'd2,
        RD_UP    = 4'd3,
        RD_DOWN  = 4'd4,
        RD_LEFT  = 4'd5,
        RD_RIGHT = 4'd6,
        RD_SELF  = 4'd7,
        DONE     = 4'd8
    } state_t;

endpackage

// File: rtl/maze_move_gate_tile_divider.sv
// Repeated-subtract pixel-to-tile converter: start loads the dividend, then
// one TILE is subtracted per cycle until the remainder drops below TILE.
module tile_divider
    import maze_move_gate_pkg::*;
#(
    parameter int TILE = DEF_TILE,
    parameter int W    = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done
);

    localparam logic [W-1:0] TILE_W = W'(TILE);

    // done is purely a remainder test so the caller may restart in the same cycle
    assign done = remainder < TILE_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            remainder <= '0;
            quotient  <= '0;
        end else if (start) begin
            remainder <= dividend;
            quotient  <= '0;
        end else if (remainder >= TILE_W) begin
            remainder <= remainder - TILE_W;
            quotient  <= quotient + 1'b1;
        end
    end

endmodule

// File: rtl/maze_move_gate.sv
// Converts the player's pixel position to a maze tile, reads its four
// neighbours and its own tile from the map ROM, and publishes move enables.
module maze_move_gate
    import maze_move_gate_pkg::*;
#(
    parameter int TILE     = DEF_TILE,
    parameter int H_ORIGIN = DEF_H_ORIGIN,
    parameter int V_ORIGIN = DEF_V_ORIGIN,
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int AW       = DEF_AW
) (
    input  logic          slowClk,
    input  logic          rst,
    input  logic [9:0]    hPos,
    input  logic [9:0]    vPos,
    output logic          map_rd,
    output logic [AW-1:0] map_addr,
    input  logic [1:0]    map_data,
    output logic          upEnable,
    output logic          downEnable,
    output logic          leftEnable,
    output logic          rightEnable,
    output logic          playerDisable,
    output logic          hazard_hit,
    output logic          busy,
    output logic [3:0]    fsm_state
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [9:0] H_O    = 10'(H_ORIGIN);
    localparam logic [9:0] V_O    = 10'(V_ORIGIN);
    localparam logic [9:0] COLS_Q = 10'(COLS);
    localparam logic [9:0] ROWS_Q = 10'(ROWS);

    state_t        state, state_next;
    logic [9:0]    last_h, last_v;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          moved, off_grid, abort;
    logic          div_start, div_done;
    logic [9:0]    div_dividend, div_q, div_rem;
    logic          rd_pend, up_open, down_open, left_open, right_open;

    assign moved     = (hPos != last_h) || (vPos != last_v);
    assign off_grid  = (hPos < H_O) || (vPos < V_O);
    assign fsm_state = state;

    function automatic logic [AW-1:0] addr_of(input int r, input int c);
        return AW'(r * COLS + c);
    endfunction

    tile_divider #(.TILE(TILE), .W(10)) u_div (
        .clk       (slowClk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (div_dividend),
        .quotient  (div_q),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_ff @(posedge slowClk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        div_start    = 1'b0;
        div_dividend = '0;
        abort        = 1'b0;
        map_rd       = 1'b0;
        map_addr     = '0;
        case (state)
            IDLE: if (moved && !off_grid) begin
                div_start    = 1'b1;
                div_dividend = hPos - H_O;
                state_next   = DIV_H;
            end
            DIV_H: if (div_done) begin
                if (div_rem != '0 || div_q >= COLS_Q) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    div_start    = 1'b1;
                    div_dividend = last_v - V_O;
                    state_next   = DIV_V;
                end
            end
            DIV_V: if (div_done) begin
                if (div_rem != '0 || div_q >= ROWS_Q) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RD_UP;
                end
            end
            // Neighbours outside the grid issue no read and later count as wall
            RD_UP: begin
                map_rd = (row != '0);
                if (map_rd) map_addr = addr_of(int'(row) - 1, int'(col));
                state_next = RD_DOWN;
            end
            RD_DOWN: begin
                map_rd = (int'(row) + 1 < ROWS);
                if (map_rd) map_addr = addr_of(int'(row) + 1, int'(col));
                state_next = RD_LEFT;
            end
            RD_LEFT: begin
                map_rd = (col != '0);
                if (map_rd) map_addr = addr_of(int'(row), int'(col) - 1);
                state_next = RD_RIGHT;
            end
            RD_RIGHT: begin
                map_rd = (int'(col) + 1 < COLS);
                if (map_rd) map_addr = addr_of(int'(row), int'(col) + 1);
                state_next = RD_SELF;
            end
            RD_SELF: begin
                map_rd     = 1'b1;
                map_addr   = addr_of(int'(row), int'(col));
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge slowClk) begin
        if (rst) begin
            last_h        <= '1;
            last_v        <= '1;
            col           <= '0;
            row           <= '0;
            busy          <= 1'b0;
            upEnable      <= 1'b0;
            downEnable    <= 1'b0;
            leftEnable    <= 1'b0;
            rightEnable   <= 1'b0;
            playerDisable <= 1'b0;
            hazard_hit    <= 1'b0;
            rd_pend       <= 1'b0;
            up_open       <= 1'b0;
            down_open     <= 1'b0;
            left_open     <= 1'b0;
            right_open    <= 1'b0;
        end else begin
            hazard_hit <= 1'b0;
            rd_pend    <= map_rd;
            if (state == IDLE && moved) begin
                last_h      <= hPos;
                last_v      <= vPos;
                busy        <= !off_grid;
                upEnable    <= 1'b0;
                downEnable  <= 1'b0;
                leftEnable  <= 1'b0;
                rightEnable <= 1'b0;
            end
            if (abort) busy <= 1'b0;
            if (state == DIV_H && div_done) col <= CW'(div_q);
            if (state == DIV_V && div_done) row <= RW'(div_q);
            // Each read state captures the answer to the previous state's read
            case (state)
                RD_DOWN:  up_open    <= rd_pend && (map_data != TILE_WALL);
                RD_LEFT:  down_open  <= rd_pend && (map_data != TILE_WALL);
                RD_RIGHT: left_open  <= rd_pend && (map_data != TILE_WALL);
                RD_SELF:  right_open <= rd_pend && (map_data != TILE_WALL);
                DONE: begin
                    upEnable    <= up_open;
                    downEnable  <= down_open;
                    leftEnable  <= left_open;
                    rightEnable <= right_open;
                    busy        <= 1'b0;
                    hazard_hit  <= (map_data == TILE_HAZARD);
                    if (map_data == TILE_GOAL) playerDisable <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
